// File: rtl/fit_attention_shift_mc.sv
// Multi-channel attention-shift tracker: per-channel error counting, Task/Self/Meta
// levels with decay hysteresis, and a round-robin valid/ready level-change event stream.
module fit_attention_shift_mc #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned SELF_TH      = 2,
  parameter int unsigned META_TH      = 5,
  parameter int unsigned META_SCORE   = 70,
  parameter int unsigned RESET_SCORE  = 90,
  parameter int unsigned DECAY_CYCLES = 16,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ern_pulse,
  input  logic [NUM_CH*SCORE_W-1:0]   score,
  input  logic [NUM_CH-1:0]           score_valid,
  output logic [NUM_CH*2-1:0]         attention_level,
  output logic [NUM_CH*CNT_W-1:0]     error_count,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [CH_W-1:0]             evt_ch,
  output logic [1:0]                  evt_level,
  output logic                        evt_coalesced
);

  localparam int unsigned TMR_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

  typedef enum logic [1:0] {
    LVL_TASK = 2'd0,
    LVL_SELF = 2'd1,
    LVL_META = 2'd2
  } level_e;

  level_e             lvl_q  [NUM_CH];
  level_e             lvl_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   cnt_d  [NUM_CH];
  logic [SCORE_W-1:0] last_q [NUM_CH];
  logic [SCORE_W-1:0] last_d [NUM_CH];
  logic [TMR_W-1:0]   tmr_q  [NUM_CH];
  logic [TMR_W-1:0]   tmr_d  [NUM_CH];

  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [NUM_CH-1:0]  merg_q, merg_d;
  logic [NUM_CH-1:0]  change;

  logic               evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]    evt_ch_q, evt_ch_d;
  level_e             evt_level_q, evt_level_d;
  logic               evt_coal_q, evt_coal_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;

  logic               gnt_found;
  logic [CH_W-1:0]    gnt_idx;

  // Per-channel counter/level update: ern beats score reset, which beats decay.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      logic [SCORE_W-1:0] sc_in;
      logic [SCORE_W-1:0] eff;
      logic [CNT_W-1:0]   cnt_inc;
      logic [CNT_W-1:0]   cnt_dec;
      sc_in   = score[c*SCORE_W +: SCORE_W];
      eff     = score_valid[c] ? sc_in : last_q[c];
      cnt_inc = (cnt_q[c] == '1) ? cnt_q[c] : cnt_q[c] + 1'b1;
      cnt_dec = cnt_q[c] - 1'b1;

      last_d[c] = eff;
      lvl_d[c]  = lvl_q[c];
      cnt_d[c]  = cnt_q[c];
      tmr_d[c]  = '0;

      if (ern_pulse[c]) begin
        cnt_d[c] = cnt_inc;
        if (32'(cnt_inc) > META_TH && 32'(eff) < META_SCORE) lvl_d[c] = LVL_META;
        else if (32'(cnt_inc) > SELF_TH)                     lvl_d[c] = LVL_SELF;
        else                                                  lvl_d[c] = LVL_TASK;
      end else if (score_valid[c] && 32'(sc_in) > RESET_SCORE) begin
        cnt_d[c] = '0;
        lvl_d[c] = LVL_TASK;
      end else if (DECAY_CYCLES != 0 && cnt_q[c] != '0) begin
        if (32'(tmr_q[c]) == DECAY_CYCLES - 1) begin
          cnt_d[c] = cnt_dec;
          // One step down at most; decay never raises the level.
          if (lvl_q[c] == LVL_META && 32'(cnt_dec) <= META_TH)      lvl_d[c] = LVL_SELF;
          else if (lvl_q[c] == LVL_SELF && 32'(cnt_dec) <= SELF_TH) lvl_d[c] = LVL_TASK;
        end else begin
          tmr_d[c] = tmr_q[c] + 1'b1;
        end
      end

      change[c] = (lvl_d[c] != lvl_q[c]);
    end
  end

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NUM_CH;
      if (!gnt_found && pend_q[CH_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_level_d = evt_level_q;
    evt_coal_d  = evt_coal_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q | change;
    merg_d      = merg_q | (pend_q & change);

    if (!evt_valid_q || evt_ready) begin
      if (gnt_found) begin
        evt_valid_d     = 1'b1;
        evt_ch_d        = gnt_idx;
        evt_level_d     = lvl_q[gnt_idx];
        evt_coal_d      = merg_q[gnt_idx];
        // A change on the granted edge re-arms pending as a fresh, unmerged event.
        pend_d[gnt_idx] = change[gnt_idx];
        merg_d[gnt_idx] = 1'b0;
        ptr_d           = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        lvl_q[c]  <= LVL_TASK;
        cnt_q[c]  <= '0;
        last_q[c] <= '0;
        tmr_q[c]  <= '0;
      end
      pend_q      <= '0;
      merg_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= LVL_TASK;
      evt_coal_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        lvl_q[c]  <= lvl_d[c];
        cnt_q[c]  <= cnt_d[c];
        last_q[c] <= last_d[c];
        tmr_q[c]  <= tmr_d[c];
      end
      pend_q      <= pend_d;
      merg_q      <= merg_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      evt_coal_q  <= evt_coal_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      attention_level[c*2 +: 2]   = lvl_q[c];
      error_count[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

  assign evt_valid     = evt_valid_q;
  assign evt_ch        = evt_ch_q;
  assign evt_level     = evt_level_q;
  assign evt_coalesced = evt_coal_q;

endmodule
